// File: rtl/relu_ctrl_pkg.sv
// Shared types and defaults for the ReLU stream controller: FSM state
// encoding and the default data/count widths.
package relu_ctrl_pkg;

   localparam int D_WIDTH_DEF = 16;
   localparam int LEN_W_DEF   = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/relu_out_stage.sv
// Single-entry registered ReLU stage: clamps negative words to zero and
// holds the result (plus its last tag) until the downstream takes it.
module relu_out_stage
   import relu_ctrl_pkg::*;
#(
   parameter int D_WIDTH = D_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic               ld_last,
   input  logic               in_valid,
   input  logic [D_WIDTH-1:0] in_data,
   output logic               in_ready,
   output logic               load,
   output logic               neg,
   output logic               out_valid,
   output logic [D_WIDTH-1:0] out_data,
   output logic               out_last,
   input  logic               out_ready
);

   // Handshake: a word moves on a rising edge where valid && ready; a
   // producer holds valid and data stable until then, and ready may depend
   // combinationally on the consumer's ready but never on valid.
   logic unload;

   assign in_ready = run && (!out_valid || out_ready);
   assign load     = in_valid && in_ready;
   assign unload   = out_valid && out_ready;
   assign neg      = in_data[D_WIDTH-1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         // A load in the same cycle as an unload simply replaces the word.
         out_valid <= 1'b1;
         out_last  <= ld_last;
         out_data  <= neg ? '0 : in_data;
      end else if (unload) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end
   end

endmodule

// File: rtl/relu_stream_ctrl.sv
// One-layer activation pass sequencer: accepts a start/len command, streams
// words through relu_out_stage, tags the last one and reports clamp count.
module relu_stream_ctrl
   import relu_ctrl_pkg::*;
#(
   parameter int D_WIDTH = D_WIDTH_DEF,
   parameter int LEN_W   = LEN_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [LEN_W-1:0]   len,
   output logic               busy,
   output logic               done,
   output logic [LEN_W-1:0]   neg_cnt,
   input  logic               in_valid,
   input  logic [D_WIDTH-1:0] in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [D_WIDTH-1:0] out_data,
   output logic               out_last,
   input  logic               out_ready,
   output logic [1:0]         dbg_state
);

   state_e           state, state_nxt;
   logic [LEN_W-1:0] rem_cnt;
   logic [LEN_W-1:0] neg_run;
   logic             run;
   logic             load;
   logic             neg;
   logic             ld_last;

   assign run       = (state == RUN);
   assign ld_last   = (rem_cnt == LEN_W'(1));
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign dbg_state = state;

   relu_out_stage #(
      .D_WIDTH (D_WIDTH)
   ) u_out_stage (
      .clk       (clk),
      .rst       (rst),
      .run       (run),
      .ld_last   (ld_last),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .load      (load),
      .neg       (neg),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (start) state_nxt = (len != '0) ? RUN : DONE;
         RUN:   if (load && ld_last) state_nxt = DRAIN;
         // No loads happen in DRAIN, so an unload here always empties the stage.
         DRAIN: if (!out_valid || out_ready) state_nxt = DONE;
         DONE:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rem_cnt <= '0;
         neg_run <= '0;
         neg_cnt <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               rem_cnt <= len;
               neg_run <= '0;
            end
            RUN: if (load) begin
               if (rem_cnt != '0) rem_cnt <= rem_cnt - LEN_W'(1);
               if (neg)           neg_run <= neg_run + LEN_W'(1);
            end
            DONE: neg_cnt <= neg_run;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Bench for relu_stream_ctrl: directed and randomized passes scored against
// a queue-based ReLU reference model.
module tb_relu_stream_ctrl;
   import relu_ctrl_pkg::*;

   localparam int DW = 16;
   localparam int LW = 10;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [LW-1:0] len = '0;
   logic          busy, done;
   logic [LW-1:0] neg_cnt;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_ready = 1'b0;
   logic [1:0]    dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [DW-1:0] in_q[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] got_q[$];
   bit            got_last_q[$];
   int            got_cyc_q[$];
   int            in_cyc_q[$];
   int            exp_neg;
   int            done_cnt = 0;
   int            done_cyc = 0;

   relu_stream_ctrl #(.D_WIDTH(DW), .LEN_W(LW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .done      (done),
      .neg_cnt   (neg_cnt),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_ready (out_ready),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- monitor (samples mid-cycle) ----------------
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            got_last_q.push_back(out_last);
            got_cyc_q.push_back(cyc);
         end
         if (in_valid && in_ready) in_cyc_q.push_back(cyc);
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   // ---------------- reference model ----------------
   function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] x);
      return ($signed(x) < 0) ? '0 : x;
   endfunction

   task automatic clear_sb();
      in_q.delete(); exp_q.delete(); got_q.delete();
      got_last_q.delete(); got_cyc_q.delete(); in_cyc_q.delete();
      exp_neg = 0;
   endtask

   task automatic model_from_in_q();
      exp_q.delete();
      exp_neg = 0;
      foreach (in_q[i]) begin
         exp_q.push_back(relu_ref(in_q[i]));
         if ($signed(in_q[i]) < 0) exp_neg++;
      end
   endtask

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) begin
         case ($urandom_range(0, 9))
            0: in_q.push_back(16'h0000);
            1: in_q.push_back(16'h8000);
            2: in_q.push_back(16'h7FFF);
            3: in_q.push_back(16'hFFFF);
            default: in_q.push_back(DW'($urandom));
         endcase
      end
      model_from_in_q();
   endtask

   // ---------------- drivers (all return at posedge + 1) ----------------
   task automatic do_start(input int l);
      start = 1'b1;
      len   = LW'(l);
      @(posedge clk); #1;
      start = 1'b0;
      len   = LW'($urandom);
   endtask

   task automatic drive_stream(input int first_idx, input int valid_pct,
                               input int ready_pct, input int budget,
                               input int inject_at, output bit timed_out);
      int idx = first_idx;
      bit in_fire;
      bit seen_done = 0;
      timed_out = 1;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         in_fire = in_valid && in_ready;
         if (done) seen_done = 1;
         @(posedge clk); #1;
         if (in_fire) idx++;
         start = (k == inject_at);
         if (start) len = LW'(7);
         if (seen_done) begin
            timed_out = 0;
            break;
         end
         if (idx < in_q.size()) begin
            if (!(in_valid && !in_fire)) in_valid = ($urandom_range(0, 99) < valid_pct);
            in_data = in_q[idx];
         end else begin
            in_valid = 1'b0;
         end
         out_ready = ($urandom_range(0, 99) < ready_pct);
      end
      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
         $display("FAIL reset_busy_done busy=%b done=%b exp=0/0", busy, done); end
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0) begin errors++;
         $display("FAIL reset_handshake in_ready=%b out_valid=%b out_last=%b exp=0", in_ready, out_valid, out_last); end
      checks++; if (out_data !== '0 || neg_cnt !== '0) begin errors++;
         $display("FAIL reset_data out_data=%h neg_cnt=%0d exp=0/0", out_data, neg_cnt); end
      checks++; if (dbg_state !== 2'd0) begin errors++;
         $display("FAIL reset_state got=%0d exp=0", dbg_state); end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_basic();
      bit to;
      int n;
      clear_sb();
      in_q = '{16'h0005, 16'hFFFE, 16'h0000, 16'h8000};
      model_from_in_q();
      n = in_q.size();
      do_start(n);
      drive_stream(0, 100, 100, 50, -1, to);
      checks++; if (to) begin errors++; $display("FAIL basic_timeout got=timeout exp=done"); end
      checks++; if (got_q.size() != n) begin errors++;
         $display("FAIL basic_count got=%0d exp=%0d", got_q.size(), n); end
      for (int i = 0; i < n && i < got_q.size(); i++) begin
         checks++; if ({got_last_q[i], got_q[i]} !== {(i == n - 1), exp_q[i]}) begin errors++;
            $display("FAIL basic_elem%0d got=%b/%h exp=%b/%h", i, got_last_q[i], got_q[i], (i == n - 1), exp_q[i]); end
      end
      checks++; if (neg_cnt !== LW'(exp_neg)) begin errors++;
         $display("FAIL basic_neg_cnt got=%0d exp=%0d", neg_cnt, exp_neg); end
      checks++; if (done_cnt != 1) begin errors++;
         $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
      if (got_q.size() == n && in_cyc_q.size() > 0) begin
         checks++; if (got_cyc_q[n-1] - got_cyc_q[0] != n - 1) begin errors++;
            $display("FAIL basic_no_bubble got_span=%0d exp=%0d", got_cyc_q[n-1] - got_cyc_q[0], n - 1); end
         checks++; if (got_cyc_q[0] != in_cyc_q[0] + 1) begin errors++;
            $display("FAIL basic_first_latency got=%0d exp=%0d", got_cyc_q[0] - in_cyc_q[0], 1); end
         checks++; if (done_cyc != got_cyc_q[n-1] + 1) begin errors++;
            $display("FAIL basic_done_latency got=%0d exp=1", done_cyc - got_cyc_q[n-1]); end
      end
   endtask

   task automatic test_len_zero();
      int d0 = done_cnt;
      clear_sb();
      do_start(0);
      @(negedge clk);
      checks++; if (busy !== 1'b1 || done !== 1'b1 || out_valid !== 1'b0) begin errors++;
         $display("FAIL len0_done_cycle busy=%b done=%b out_valid=%b exp=1/1/0", busy, done, out_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++;
         $display("FAIL len0_after busy=%b done=%b exp=0/0", busy, done); end
      checks++; if (neg_cnt !== '0) begin errors++;
         $display("FAIL len0_neg_cnt got=%0d exp=0", neg_cnt); end
      checks++; if (done_cnt - d0 != 1 || got_q.size() != 0) begin errors++;
         $display("FAIL len0_single_done dones=%0d outputs=%0d exp=1/0", done_cnt - d0, got_q.size()); end
      @(posedge clk); #1;
   endtask

   task automatic test_stall();
      bit to;
      int d0 = done_cnt;
      clear_sb();
      fill_random(3);
      do_start(3);
      in_valid = 1'b1; in_data = in_q[0]; out_ready = 1'b1;
      @(posedge clk); #1;
      in_data = in_q[1]; out_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== exp_q[0] || out_last !== 1'b0) begin errors++;
            $display("FAIL stall_hold%0d in_ready=%b out_valid=%b out_data=%h out_last=%b exp=0/1/%h/0",
                     s, in_ready, out_valid, out_data, out_last, exp_q[0]); end
         @(posedge clk); #1;
      end
      drive_stream(1, 100, 100, 50, -1, to);
      checks++; if (to || got_q.size() != 3) begin errors++;
         $display("FAIL stall_count got=%0d timeout=%0d exp=3/0", got_q.size(), to); end
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         checks++; if ({got_last_q[i], got_q[i]} !== {(i == 2), exp_q[i]}) begin errors++;
            $display("FAIL stall_elem%0d got=%b/%h exp=%b/%h", i, got_last_q[i], got_q[i], (i == 2), exp_q[i]); end
      end
      checks++; if (neg_cnt !== LW'(exp_neg) || done_cnt - d0 != 1) begin errors++;
         $display("FAIL stall_summary neg_cnt=%0d dones=%0d exp=%0d/1", neg_cnt, done_cnt - d0, exp_neg); end
   endtask

   task automatic test_start_ignored();
      bit to;
      int d0 = done_cnt;
      clear_sb();
      fill_random(4);
      do_start(4);
      drive_stream(0, 100, 100, 60, 2, to);
      checks++; if (to || got_q.size() != 4) begin errors++;
         $display("FAIL ignore_count got=%0d timeout=%0d exp=4/0", got_q.size(), to); end
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         checks++; if ({got_last_q[i], got_q[i]} !== {(i == 3), exp_q[i]}) begin errors++;
            $display("FAIL ignore_elem%0d got=%b/%h exp=%b/%h", i, got_last_q[i], got_q[i], (i == 3), exp_q[i]); end
      end
      repeat (3) @(posedge clk); #1;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || done_cnt - d0 != 1 || neg_cnt !== LW'(exp_neg)) begin errors++;
         $display("FAIL ignore_after busy=%b dones=%0d neg_cnt=%0d exp=0/1/%0d", busy, done_cnt - d0, neg_cnt, exp_neg); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_pass();
      bit to;
      int d0;
      clear_sb();
      fill_random(5);
      do_start(5);
      in_valid = 1'b1; in_data = in_q[0]; out_ready = 1'b1;
      @(posedge clk); #1;
      in_data = in_q[1];
      @(posedge clk); #1;
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_last !== 1'b0) begin errors++;
         $display("FAIL midrst_out out_valid=%b out_data=%h out_last=%b exp=0", out_valid, out_data, out_last); end
      checks++; if (busy !== 1'b0 || in_ready !== 1'b0 || neg_cnt !== '0 || dbg_state !== 2'd0) begin errors++;
         $display("FAIL midrst_ctrl busy=%b in_ready=%b neg_cnt=%0d state=%0d exp=0", busy, in_ready, neg_cnt, dbg_state); end
      d0 = done_cnt;
      out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(posedge clk); #1;
      checks++; if (done_cnt != d0 || busy !== 1'b0) begin errors++;
         $display("FAIL midrst_no_done dones=%0d busy=%b exp=0/0", done_cnt - d0, busy); end
      clear_sb();
      fill_random(2);
      do_start(2);
      drive_stream(0, 100, 100, 50, -1, to);
      checks++; if (to || got_q.size() != 2 || done_cnt - d0 != 1) begin errors++;
         $display("FAIL midrst_repass outputs=%0d dones=%0d timeout=%0d exp=2/1/0", got_q.size(), done_cnt - d0, to); end
      for (int i = 0; i < 2 && i < got_q.size(); i++) begin
         checks++; if ({got_last_q[i], got_q[i]} !== {(i == 1), exp_q[i]}) begin errors++;
            $display("FAIL midrst_elem%0d got=%b/%h exp=%b/%h", i, got_last_q[i], got_q[i], (i == 1), exp_q[i]); end
      end
      checks++; if (neg_cnt !== LW'(exp_neg)) begin errors++;
         $display("FAIL midrst_neg_cnt got=%0d exp=%0d", neg_cnt, exp_neg); end
   endtask

   task automatic test_full_throughput();
      bit to;
      int n = 1023;
      int bad = 0;
      clear_sb();
      for (int i = 0; i < n; i++) in_q.push_back(16'hFFFF);
      model_from_in_q();
      do_start(n);
      drive_stream(0, 100, 100, 1300, -1, to);
      checks++; if (to || got_q.size() != n) begin errors++;
         $display("FAIL max_count got=%0d timeout=%0d exp=%0d/0", got_q.size(), to, n); end
      for (int i = 0; i < n && i < got_q.size(); i++)
         if ({got_last_q[i], got_q[i]} !== {(i == n - 1), exp_q[i]}) bad++;
      checks++; if (bad != 0) begin errors++;
         $display("FAIL max_elements got=%0d wrong exp=0 wrong", bad); end
      if (got_q.size() == n) begin
         checks++; if (got_cyc_q[n-1] - got_cyc_q[0] != n - 1) begin errors++;
            $display("FAIL max_no_bubble got_span=%0d exp=%0d", got_cyc_q[n-1] - got_cyc_q[0], n - 1); end
      end
      checks++; if (neg_cnt !== LW'(exp_neg)) begin errors++;
         $display("FAIL max_neg_cnt got=%0d exp=%0d", neg_cnt, exp_neg); end
   endtask

   task automatic test_random_passes();
      bit to;
      int n, d0;
      for (int p = 0; p < 6; p++) begin
         clear_sb();
         n  = $urandom_range(1, 40);
         d0 = done_cnt;
         fill_random(n);
         do_start(n);
         drive_stream(0, $urandom_range(30, 100), $urandom_range(30, 100), 2000, -1, to);
         checks++; if (to || got_q.size() != n || done_cnt - d0 != 1) begin errors++;
            $display("FAIL rand%0d_count outputs=%0d dones=%0d timeout=%0d exp=%0d/1/0", p, got_q.size(), done_cnt - d0, to, n); end
         for (int i = 0; i < n && i < got_q.size(); i++) begin
            checks++; if ({got_last_q[i], got_q[i]} !== {(i == n - 1), exp_q[i]}) begin errors++;
               $display("FAIL rand%0d_elem%0d got=%b/%h exp=%b/%h", p, i, got_last_q[i], got_q[i], (i == n - 1), exp_q[i]); end
         end
         checks++; if (neg_cnt !== LW'(exp_neg)) begin errors++;
            $display("FAIL rand%0d_neg_cnt got=%0d exp=%0d", p, neg_cnt, exp_neg); end
         if (got_q.size() == n) begin
            checks++; if (done_cyc != got_cyc_q[n-1] + 1) begin errors++;
               $display("FAIL rand%0d_done_latency got=%0d exp=1", p, done_cyc - got_cyc_q[n-1]); end
         end
      end
   endtask

   // ---------------- sequence and final report ----------------
   initial begin
      test_reset();
      test_basic();
      test_len_zero();
      test_stall();
      test_start_ignored();
      test_reset_mid_pass();
      test_full_throughput();
      test_random_passes();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
